multiple_accum_dump: RTL and testbench
======================================

Name: multiple_accum_dump

Overview:
Per-channel integrate-and-dump stage that consumes the full-precision product arrays produced by the multi-channel gain stage. It sums a programmable number of valid samples per channel and rounds the sum down by a fixed shift. It then saturates the result to the output width and emits one result array per frame with a single-cycle valid pulse. The block sits directly downstream of the gain stage and reduces the sample rate and word width for the next processing stage.

Parameters:
DATA_WIDTH, 16, gain-stage input width; input samples are 2*DATA_WIDTH bits wide.
NUM_INOUT, 8, number of parallel channels.
IS_SIGNED, 1, 1 = two's-complement arithmetic, 0 = unsigned.
ACC_LEN_W, 8, width of the frame-length input; maximum frame length is 2^ACC_LEN_W-1.
SHIFT, 8, right shift applied to the accumulated sum; 0 means no rounding.
OUT_WIDTH, 16, output word width; must be <= 2*DATA_WIDTH+ACC_LEN_W-SHIFT.

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous reset, active low
i_ena  in  1  clock enable; when low, every register holds
i_clear  in  1  synchronous abort of the current frame
i_len  in  ACC_LEN_W  samples per frame; sampled on the first sample of each frame
i_valid  in  1  input sample qualifier
i_data  in  [2*DATA_WIDTH-1:0] x NUM_INOUT  product arrays from the gain stage
o_valid  out  1  one-cycle pulse marking a new result
o_data  out  [OUT_WIDTH-1:0] x NUM_INOUT  rounded, saturated frame sums
o_sat  out  1  at least one channel of the current result was clamped
o_busy  out  1  a frame is in progress (sample count > 0)

Behaviour:
- Reset (async, i_rst_n=0) forces o_valid=0, o_data all 0, o_sat=0, o_busy=0, sample counter=0, accumulators=0, and the dump-stage valid flag=0. This takes effect immediately, regardless of i_clk or i_ena.
- The accumulator width per channel is ACC_W = 2*DATA_WIDTH+ACC_LEN_W. Inputs are sign-extended when IS_SIGNED=1 and zero-extended when IS_SIGNED=0.
- All updates below occur only on rising edges with i_ena=1.
- A sample is accepted when i_valid=1 and i_clear=0.
  - First sample of a frame (counter=0): latch i_len, treating 0 as 1; load acc = input.
  - Otherwise: acc = acc + input. Counter increments.
- Last sample (counter == latched length-1):
  - Write acc+input into the dump register and set dump_valid.
  - Reset counter to 0 and the accumulator to 0.
  - A sample on the very next cycle starts the new frame with no bubble.
- Stage 2, on the cycle after dump_valid=1:
  - r = (dump + 2^(SHIFT-1)) >>> SHIFT. The shift is arithmetic when signed, logical when unsigned; no added term when SHIFT=0. The add is performed at ACC_W+1 bits so it cannot overflow.
  - Saturate r. Signed range is [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; unsigned range is [0, 2^OUT_WIDTH-1].
  - Register r to o_data, set o_valid=1, set o_sat = OR of per-channel clamps, then clear dump_valid.
- Latency: o_valid rises exactly 2 enabled edges after the edge that accepted the last sample.
- o_valid is high for exactly one enabled cycle. If i_ena drops while o_valid=1, o_valid holds until the next enabled edge.
- o_data and o_sat hold their values between results.
- i_valid=0 gaps inside a frame leave the counter and accumulators unchanged.
- i_len changes mid-frame are ignored until the next frame starts.
- i_clear=1 on an enabled edge:
  - Counter and accumulators go to 0, and dump_valid is cleared, so a pending dump is discarded.
  - o_valid=0 next cycle; o_data and o_sat hold.
  - i_clear has priority over a simultaneous i_valid, and that sample is dropped.
- o_busy = (counter != 0).
- The block has no backpressure, so the consumer must accept every o_valid pulse.

Test Plan:
1. DATA_WIDTH=16, NUM_INOUT=4, ACC_LEN_W=4, SHIFT=4, OUT_WIDTH=16, signed; i_len=4.
   - Stimulus: ch0 = 10,20,30,40; ch1 = -16 four times.
   - Required: o_valid 2 cycles after the 4th sample; ch0=6 (108>>4); ch1=-4 (-56>>>4); o_sat=0.
2. Same configuration, i_len=2.
   - Stimulus: ch0 = 0x40000000 twice; ch1 = 0xC0000000 twice.
   - Required: ch0=32767, ch1=-32768, o_sat=1.
3. i_len=0 with i_valid high on 5 consecutive cycles.
   - Required: 5 consecutive o_valid pulses, each output equal to the rounded single sample.
   - Also: no bubble between frames; o_busy stays 0.
4. i_len=3 with i_valid gaps of 2 cycles between samples, and i_ena low for 3 cycles during stage 2.
   - Required: the sum is unaffected by the gaps.
   - Required: o_valid is delayed by 3 cycles and stays high for the 3 frozen cycles, then drops after one enabled cycle.
5. Async reset asserted mid-clock after 2 of 4 samples.
   - Required: outputs are 0 immediately.
   - Required: after release, a fresh 4-sample frame of 16s gives 4 per channel, with no residue from the earlier samples.
6. i_clear asserted together with the last sample of a frame.
   - Required: no o_valid; o_data keeps its previous result.
   - Required: the next full frame produces a correct result.

Source files
------------

// File: rtl/multiple_accum_dump.sv
// Per-channel integrate-and-dump: sums a programmable number of samples per channel,
// then rounds, shifts and saturates each frame sum into a one-cycle result pulse.
module multiple_accum_dump #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_INOUT  = 8,
  parameter int unsigned IS_SIGNED  = 1,
  parameter int unsigned ACC_LEN_W  = 8,
  parameter int unsigned SHIFT      = 8,
  parameter int unsigned OUT_WIDTH  = 16
) (
  input  logic                                     i_clk,
  input  logic                                     i_rst_n,
  input  logic                                     i_ena,
  input  logic                                     i_clear,
  input  logic [ACC_LEN_W-1:0]                     i_len,
  input  logic                                     i_valid,
  input  logic [NUM_INOUT-1:0][2*DATA_WIDTH-1:0]   i_data,
  output logic                                     o_valid,
  output logic [NUM_INOUT-1:0][OUT_WIDTH-1:0]      o_data,
  output logic                                     o_sat,
  output logic                                     o_busy
);

  localparam int unsigned IN_W  = 2 * DATA_WIDTH;
  localparam int unsigned ACC_W = IN_W + ACC_LEN_W;
  // Two guard bits: one for the rounding add, one so unsigned sums stay positive when treated as signed.
  localparam int unsigned EXT_W = ACC_W + 2;

  localparam logic signed [EXT_W-1:0] RND_C = (EXT_W'(1) << SHIFT) >> 1;
  localparam logic signed [EXT_W-1:0] MAX_C = (IS_SIGNED != 0)
                                              ? (EXT_W'(1) << (OUT_WIDTH - 1)) - EXT_W'(1)
                                              : (EXT_W'(1) << OUT_WIDTH) - EXT_W'(1);
  localparam logic signed [EXT_W-1:0] MIN_C = (IS_SIGNED != 0)
                                              ? -(EXT_W'(1) << (OUT_WIDTH - 1))
                                              : EXT_W'(0);

  logic [ACC_LEN_W-1:0]                   cnt_q, cnt_d;
  logic [ACC_LEN_W-1:0]                   len_q, len_d;
  logic [NUM_INOUT-1:0][ACC_W-1:0]        acc_q, acc_d;
  logic [NUM_INOUT-1:0][ACC_W-1:0]        dump_q, dump_d;
  logic                                   dump_valid_q, dump_valid_d;
  logic                                   valid_q, valid_d;
  logic [NUM_INOUT-1:0][OUT_WIDTH-1:0]    data_q, data_d;
  logic                                   sat_q, sat_d;
  logic                                   busy_q, busy_d;

  logic [NUM_INOUT-1:0][ACC_W-1:0]        in_ext;
  logic [NUM_INOUT-1:0][ACC_W-1:0]        sum;
  logic [NUM_INOUT-1:0][EXT_W-1:0]        ext_v;
  logic [NUM_INOUT-1:0][EXT_W-1:0]        shr;
  logic [NUM_INOUT-1:0][OUT_WIDTH-1:0]    rnd_out;
  logic                                   clamp_any;
  logic                                   first;
  logic                                   last;
  logic [ACC_LEN_W-1:0]                   len_eff;

  // Dump stage: round, shift and clamp every channel of the pending frame sum.
  always_comb begin
    clamp_any = 1'b0;
    ext_v     = '0;
    shr       = '0;
    rnd_out   = '0;
    for (int unsigned c = 0; c < NUM_INOUT; c++) begin
      ext_v[c] = (IS_SIGNED != 0) ? {{2{dump_q[c][ACC_W-1]}}, dump_q[c]}
                                  : {2'b00, dump_q[c]};
      shr[c]   = $signed(ext_v[c] + RND_C) >>> SHIFT;
      if ($signed(shr[c]) > MAX_C) begin
        rnd_out[c] = MAX_C[OUT_WIDTH-1:0];
        clamp_any  = 1'b1;
      end else if ($signed(shr[c]) < MIN_C) begin
        rnd_out[c] = MIN_C[OUT_WIDTH-1:0];
        clamp_any  = 1'b1;
      end else begin
        rnd_out[c] = shr[c][OUT_WIDTH-1:0];
      end
    end
  end

  // Accumulate stage and output register next-state.
  always_comb begin
    cnt_d        = cnt_q;
    len_d        = len_q;
    acc_d        = acc_q;
    dump_d       = dump_q;
    dump_valid_d = 1'b0;
    valid_d      = 1'b0;
    data_d       = data_q;
    sat_d        = sat_q;
    in_ext       = '0;
    sum          = '0;

    first   = (cnt_q == ACC_LEN_W'(0));
    len_eff = first ? ((i_len == ACC_LEN_W'(0)) ? ACC_LEN_W'(1) : i_len) : len_q;
    last    = (cnt_q == len_eff - ACC_LEN_W'(1));

    for (int unsigned c = 0; c < NUM_INOUT; c++) begin
      in_ext[c] = (IS_SIGNED != 0) ? {{ACC_LEN_W{i_data[c][IN_W-1]}}, i_data[c]}
                                   : {ACC_LEN_W'(0), i_data[c]};
      sum[c]    = (first ? ACC_W'(0) : acc_q[c]) + in_ext[c];
    end

    if (i_clear) begin
      cnt_d = '0;
      acc_d = '0;
    end else begin
      valid_d = dump_valid_q;
      if (dump_valid_q) begin
        data_d = rnd_out;
        sat_d  = clamp_any;
      end
      if (i_valid) begin
        if (first) begin
          len_d = len_eff;
        end
        if (last) begin
          dump_d       = sum;
          dump_valid_d = 1'b1;
          cnt_d        = '0;
          acc_d        = '0;
        end else begin
          acc_d = sum;
          cnt_d = cnt_q + ACC_LEN_W'(1);
        end
      end
    end

    busy_d = (cnt_d != ACC_LEN_W'(0));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q        <= '0;
      len_q        <= '0;
      acc_q        <= '0;
      dump_q       <= '0;
      dump_valid_q <= 1'b0;
      valid_q      <= 1'b0;
      data_q       <= '0;
      sat_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else if (i_ena) begin
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      acc_q        <= acc_d;
      dump_q       <= dump_d;
      dump_valid_q <= dump_valid_d;
      valid_q      <= valid_d;
      data_q       <= data_d;
      sat_q        <= sat_d;
      busy_q       <= busy_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_sat   = sat_q;
  assign o_busy  = busy_q;

endmodule

// File: tb/tb_multiple_accum_dump.sv
// Directed bench for multiple_accum_dump: stimulus pushes hand-computed results into a
// scoreboard queue, a negedge monitor pops and compares on every fresh o_valid.
module tb_multiple_accum_dump;

  localparam int unsigned DW  = 16;
  localparam int unsigned N   = 4;
  localparam int unsigned ALW = 4;
  localparam int unsigned SH  = 4;
  localparam int unsigned OW  = 16;

  typedef struct {
    logic [N-1:0][OW-1:0] data;
    logic                 sat;
    int                   cyc;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   ena;
  logic                   clr;
  logic [ALW-1:0]         len;
  logic                   vld;
  logic [N-1:0][2*DW-1:0] din;
  logic                   o_valid;
  logic [N-1:0][OW-1:0]   o_data;
  logic                   o_sat;
  logic                   o_busy;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic en_at_edge;

  multiple_accum_dump #(
    .DATA_WIDTH(DW), .NUM_INOUT(N), .IS_SIGNED(1),
    .ACC_LEN_W(ALW), .SHIFT(SH), .OUT_WIDTH(OW)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_ena(ena), .i_clear(clr), .i_len(len),
    .i_valid(vld), .i_data(din), .o_valid(o_valid), .o_data(o_data),
    .o_sat(o_sat), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) en_at_edge <= 1'b0;
    else        en_at_edge <= ena;
  end

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // A result counts once, on the enabled edge that raised it; frozen cycles are not new results.
  always @(negedge clk) begin
    exp_t item;
    if (rst_n && o_valid && en_at_edge) begin
      if (exp_q.size() == 0) begin
        chk("spurious_o_valid", 64'(o_valid), 64'(0));
      end else begin
        item = exp_q.pop_front();
        for (int c = 0; c < N; c++) chk($sformatf("data_ch%0d", c), 64'(o_data[c]), 64'(item.data[c]));
        chk("sat", 64'(o_sat), 64'(item.sat));
        chk("latency_cycle", 64'(cyc), 64'(item.cyc));
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] d0, d1, d2, d3);
    vld = v; din[0] = d0; din[1] = d1; din[2] = d2; din[3] = d3;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    vld = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Call right before driving the last sample of a frame; dly counts edges to the result.
  task automatic push_exp(input logic [15:0] e0, e1, e2, e3, input logic s, input int dly);
    exp_t item;
    item.data[0] = e0; item.data[1] = e1; item.data[2] = e2; item.data[3] = e3;
    item.sat = s;
    item.cyc = cyc + dly;
    exp_q.push_back(item);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ena = 1'b1; clr = 1'b0; len = '0; vld = 1'b0; din = '0;
    #3;
    chk("reset_o_valid", 64'(o_valid), 64'(0));
    chk("reset_o_data", 64'(o_data), 64'(0));
    chk("reset_o_sat", 64'(o_sat), 64'(0));
    chk("reset_o_busy", 64'(o_busy), 64'(0));
    @(posedge clk); @(posedge clk); #4 rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic 4-sample frame with round-to-nearest on both signs.
    len = 4'd4;
    drive(1, 32'd10, 32'(-16), 32'd5, 32'(-5));
    drive(1, 32'd20, 32'(-16), 32'd5, 32'(-5));
    drive(1, 32'd30, 32'(-16), 32'd5, 32'(-5));
    push_exp(16'd6, 16'(-4), 16'd1, 16'(-1), 1'b0, 2);
    drive(1, 32'd40, 32'(-16), 32'd5, 32'(-5));
    idle(3);

    // Saturation at both rails.
    len = 4'd2;
    drive(1, 32'h4000_0000, 32'hC000_0000, 32'h7FFF_FFFF, 32'd0);
    push_exp(16'd32767, 16'h8000, 16'd32767, 16'd0, 1'b1, 2);
    drive(1, 32'h4000_0000, 32'hC000_0000, 32'h7FFF_FFFF, 32'd0);
    idle(3);

    // Length 0 behaves as 1: back-to-back single-sample frames, never busy.
    len = 4'd0;
    for (int k = 0; k < 5; k++) begin
      push_exp(16'(k + 1), 16'(-(k + 1)), 16'd0, 16'd1, 1'b0, 2);
      drive(1, 32'(16 * (k + 1)), 32'(-16 * (k + 1)), 32'd7, 32'd8);
      chk("len0_busy", 64'(o_busy), 64'(0));
    end
    idle(3);

    // Gapped frame, mid-frame length change ignored, enable dropped while the dump is pending.
    len = 4'd3;
    drive(1, 32'd100, 32'(-100), 32'd1, 32'h0001_0000);
    chk("gap_busy_a", 64'(o_busy), 64'(1));
    len = 4'd1;
    idle(2);
    chk("gap_busy_b", 64'(o_busy), 64'(1));
    drive(1, 32'd200, 32'(-200), 32'd1, 32'h0001_0000);
    idle(2);
    push_exp(16'd38, 16'(-37), 16'd0, 16'd12288, 1'b0, 5);
    drive(1, 32'd300, 32'(-300), 32'd1, 32'h0001_0000);
    vld = 1'b0; ena = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("frozen_pending_valid", 64'(o_valid), 64'(0));
    end
    ena = 1'b1;
    idle(3);

    // Enable dropped while o_valid is high: it must hold, then clear after one enabled edge.
    len = 4'd3;
    drive(1, 32'd16, 32'(-16), 32'd0, 32'd0);
    drive(1, 32'd16, 32'(-16), 32'd0, 32'd0);
    push_exp(16'd3, 16'(-3), 16'd0, 16'd0, 1'b0, 2);
    drive(1, 32'd16, 32'(-16), 32'd0, 32'd0);
    idle(1);
    chk("valid_before_freeze", 64'(o_valid), 64'(1));
    ena = 1'b0;
    repeat (3) begin
      idle(1);
      chk("valid_held_frozen", 64'(o_valid), 64'(1));
    end
    ena = 1'b1;
    idle(1);
    chk("valid_drop_after_enable", 64'(o_valid), 64'(0));
    idle(2);

    // Async reset in the middle of a frame.
    len = 4'd4;
    drive(1, 32'd1000, 32'd1000, 32'd1000, 32'd1000);
    drive(1, 32'd1000, 32'd1000, 32'd1000, 32'd1000);
    vld = 1'b0;
    chk("busy_before_reset", 64'(o_busy), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_o_valid", 64'(o_valid), 64'(0));
    chk("midreset_o_data", 64'(o_data), 64'(0));
    chk("midreset_o_sat", 64'(o_sat), 64'(0));
    chk("midreset_o_busy", 64'(o_busy), 64'(0));
    @(posedge clk); #4 rst_n = 1'b1;
    @(posedge clk); #1;
    drive(1, 32'd16, 32'd16, 32'd16, 32'd16);
    drive(1, 32'd16, 32'd16, 32'd16, 32'd16);
    drive(1, 32'd16, 32'd16, 32'd16, 32'd16);
    push_exp(16'd4, 16'd4, 16'd4, 16'd4, 1'b0, 2);
    drive(1, 32'd16, 32'd16, 32'd16, 32'd16);
    idle(3);

    // Clear together with the last sample: frame discarded, previous result held.
    len = 4'd3;
    drive(1, 32'd1, 32'd2, 32'd3, 32'd4);
    drive(1, 32'd1, 32'd2, 32'd3, 32'd4);
    clr = 1'b1;
    drive(1, 32'd1, 32'd2, 32'd3, 32'd4);
    clr = 1'b0;
    idle(5);
    chk("clear_hold_o_data", 64'(o_data), {16'd4, 16'd4, 16'd4, 16'd4});
    chk("clear_hold_o_sat", 64'(o_sat), 64'(0));
    chk("clear_busy", 64'(o_busy), 64'(0));
    drive(1, 32'd160, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'(-8));
    drive(1, 32'd160, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'(-8));
    push_exp(16'd30, 16'd32767, 16'd0, 16'hFFFF, 1'b1, 2);
    drive(1, 32'd160, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'(-8));
    idle(4);

    for (int w = 0; w < 20 && exp_q.size() != 0; w++) idle(1);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
